// File: rtl/csr_counter_pkg.sv
// Shared types and constants for the machine-mode counter CSR block.
package csr_counter_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } fsm_t;

  localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;

  localparam int INH_CY = 0;
  localparam int INH_IR = 2;

  // Read-modify-write result for the non-READ ops.
  function automatic logic [31:0] apply_op(csr_op_t op, logic [31:0] old_val,
                                           logic [31:0] wdata);
    case (op)
      OP_WRITE: apply_op = wdata;
      OP_SET:   apply_op = old_val | wdata;
      OP_CLEAR: apply_op = old_val & ~wdata;
      default:  apply_op = old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// One WIDTH-bit free-running counter with independent 32-bit half writes.
module csr_counter64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [WIDTH-1:0] count
);

  localparam int HI_W = WIDTH - 32;

  logic [31:0] lo_inc;

  assign lo_inc = count[31:0] + {31'b0, inc_en};

  // A low-half write freezes the high half; a high-half write lets the low
  // half keep counting but throws its carry away.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!reset)
      count <= '0;
    else if (wr_lo)
      count <= {count[WIDTH-1:32], wdata};
    else if (wr_hi)
      count <= {wdata[HI_W-1:0], lo_inc};
    else
      count <= count + {{(WIDTH-1){1'b0}}, inc_en};
  end

endmodule

// File: rtl/csr_counter_unit.sv
// Machine-mode counter CSR block: mcycle, minstret and mcountinhibit with a
// one-cycle valid/ready request/response interface.
module csr_counter_unit
  import csr_counter_pkg::*;
#(
  parameter int         WIDTH         = 64,
  parameter logic [2:0] INHIBIT_RESET = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_addr,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_illegal,
  input  logic        retire
);

  fsm_t             state, state_next;
  csr_op_t          op;
  logic             accept;
  logic             inh_cy, inh_ir;
  logic [WIDTH-1:0] mcycle, minstret;
  logic [31:0]      mcycle_hi, minstret_hi;
  logic [31:0]      old_val, new_val;
  logic             known, read_only, illegal, do_write;
  logic             wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi, wr_inh;

  assign op     = csr_op_t'(req_op);
  assign accept = req_valid && req_ready;

  // High halves are zero-padded when WIDTH is below 64.
  always_comb begin
    mcycle_hi                  = '0;
    minstret_hi                = '0;
    mcycle_hi[WIDTH-33:0]      = mcycle[WIDTH-1:32];
    minstret_hi[WIDTH-33:0]    = minstret[WIDTH-1:32];
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    old_val   = '0;
    known     = 1'b1;
    case (req_addr)
      ADDR_MCYCLE, ADDR_CYCLE:       old_val = mcycle[31:0];
      ADDR_MCYCLEH, ADDR_CYCLEH:     old_val = mcycle_hi;
      ADDR_MINSTRET, ADDR_INSTRET:   old_val = minstret[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: old_val = minstret_hi;
      ADDR_MCOUNTINHIBIT:            old_val = {29'b0, inh_ir, 1'b0, inh_cy};
      default:                       known   = 1'b0;
    endcase
    read_only = (req_addr[11:8] == 4'hC);
    illegal   = !known || (op != OP_READ && read_only);
    do_write  = accept && (op != OP_READ) && !illegal;
    wr_cyc_lo = do_write && (req_addr == ADDR_MCYCLE);
    wr_cyc_hi = do_write && (req_addr == ADDR_MCYCLEH);
    wr_ins_lo = do_write && (req_addr == ADDR_MINSTRET);
    wr_ins_hi = do_write && (req_addr == ADDR_MINSTRETH);
    wr_inh    = do_write && (req_addr == ADDR_MCOUNTINHIBIT);
  end

  assign new_val = apply_op(op, old_val, req_wdata);

  // Increments always see the inhibit value from before this edge.
  csr_counter64 #(.WIDTH(WIDTH)) u_mcycle (
    .clk    (clk),
    .reset  (reset),
    .inc_en (!inh_cy),
    .wr_lo  (wr_cyc_lo),
    .wr_hi  (wr_cyc_hi),
    .wdata  (new_val),
    .count  (mcycle)
  );

  csr_counter64 #(.WIDTH(WIDTH)) u_minstret (
    .clk    (clk),
    .reset  (reset),
    .inc_en (retire && !inh_ir),
    .wr_lo  (wr_ins_lo),
    .wr_hi  (wr_ins_hi),
    .wdata  (new_val),
    .count  (minstret)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      inh_cy <= INHIBIT_RESET[INH_CY];
      inh_ir <= INHIBIT_RESET[INH_IR];
    end else if (wr_inh) begin
      inh_cy <= new_val[INH_CY];
      inh_ir <= new_val[INH_IR];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_rdata   <= '0;
      resp_illegal <= 1'b0;
    end else if (accept) begin
      resp_rdata   <= illegal ? 32'b0 : old_val;
      resp_illegal <= illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

endmodule

// File: tb/tb_csr_counter_unit.sv
// Directed bench for csr_counter_unit; edges are counted from reset release.
module tb_csr_counter_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic [1:0]  req_op;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_illegal;
  logic        retire;

  int checks   = 0;
  int failures = 0;

  csr_counter_unit #(.WIDTH(64), .INHIBIT_RESET(3'b000)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_op       (req_op),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_illegal (resp_illegal),
    .retire       (retire)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request for a single edge; returns at the following negedge.
  task automatic xact(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic [31:0] rdata, input logic ill);
    check({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "_rdata"}, resp_rdata, rdata);
    check({tag, "_illegal"}, {31'b0, resp_illegal}, {31'b0, ill});
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_op = 2'b00;
    req_wdata = '0; resp_ready = 1'b1; retire = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_illegal", {31'b0, resp_illegal}, 32'd0);
    reset = 1'b1;

    // Ten idle edges, then the read is accepted on edge 11.
    repeat (10) @(negedge clk);
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);
    check("idle_resp_valid", {31'b0, resp_valid}, 32'd0);
    xact(2'b00, 12'hB00, 32'h0);
    check_resp("rd_mcycle10", 32'd10, 1'b0);
    check("rd_req_ready_low", {31'b0, req_ready}, 32'd0);

    @(negedge clk);
    xact(2'b01, 12'hB00, 32'hFFFF_FFFF);
    check_resp("wr_lo_old", 32'd12, 1'b0);
    @(negedge clk);
    xact(2'b00, 12'hB80, 32'h0);
    check_resp("carry_hi", 32'd1, 1'b0);

    // Write the high half on the edge where the low half wraps.
    @(negedge clk);
    xact(2'b01, 12'hB00, 32'hFFFF_FFFE);
    check_resp("wr_lo2_old", 32'd2, 1'b0);
    @(negedge clk);
    xact(2'b01, 12'hB80, 32'h5);
    check_resp("wr_hi_old", 32'd1, 1'b0);
    @(negedge clk);
    xact(2'b00, 12'hC80, 32'h0);
    check_resp("hi_no_carry", 32'd5, 1'b0);
    @(negedge clk);
    xact(2'b00, 12'hB00, 32'h0);
    check_resp("lo_after_wrap", 32'd3, 1'b0);

    // Inhibit both counters; the accept edge still counts with old inhibit.
    @(negedge clk);
    retire = 1'b1;
    xact(2'b10, 12'h320, 32'h5);
    check_resp("set_inh_old", 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    retire = 1'b0;
    xact(2'b00, 12'hC02, 32'h0);
    check_resp("instret_frozen", 32'd1, 1'b0);
    @(negedge clk);
    xact(2'b00, 12'hB00, 32'h0);
    check_resp("mcycle_frozen", 32'd6, 1'b0);
    @(negedge clk);
    xact(2'b00, 12'h320, 32'h0);
    check_resp("rd_inhibit", 32'd5, 1'b0);
    @(negedge clk);
    xact(2'b11, 12'h320, 32'h4);
    check_resp("clr_inh_old", 32'd5, 1'b0);
    retire = 1'b1;
    @(negedge clk);
    retire = 1'b0;
    xact(2'b00, 12'hB02, 32'h0);
    check_resp("instret_resume", 32'd2, 1'b0);

    // Illegal accesses.
    @(negedge clk);
    xact(2'b01, 12'hC00, 32'h1234);
    check_resp("wr_ro_illegal", 32'd0, 1'b1);
    @(negedge clk);
    xact(2'b00, 12'h123, 32'h0);
    check_resp("unmapped_illegal", 32'd0, 1'b1);

    // Response back-pressure; a request held on the bus must be ignored.
    @(negedge clk);
    resp_ready = 1'b0;
    xact(2'b10, 12'hB00, 32'h100);
    check_resp("bp_cyc0", 32'd6, 1'b0);
    check("bp_ready0", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b1; req_op = 2'b00; req_addr = 12'hB00;
    @(negedge clk);
    check_resp("bp_cyc1", 32'd6, 1'b0);
    check("bp_ready1", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check_resp("bp_cyc2", 32'd6, 1'b0);
    resp_ready = 1'b1;
    @(negedge clk);
    check("no_b2b_valid", {31'b0, resp_valid}, 32'd0);
    check("no_b2b_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check_resp("set_result", 32'h106, 1'b0);

    // Reset while a response is pending.
    @(negedge clk);
    retire = 1'b1;
    repeat (5) @(negedge clk);
    retire = 1'b0;
    resp_ready = 1'b0;
    xact(2'b00, 12'hB02, 32'h0);
    check_resp("instret7", 32'd7, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
    check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    check("mid_rst_rdata", resp_rdata, 32'd0);
    resp_ready = 1'b1;
    xact(2'b00, 12'h320, 32'h0);
    check_resp("inh_after_rst", 32'd0, 1'b0);
    @(negedge clk);
    xact(2'b00, 12'hB02, 32'h0);
    check_resp("instret_after_rst", 32'd0, 1'b0);
    @(negedge clk);
    xact(2'b00, 12'hB00, 32'h0);
    check_resp("mcycle_after_rst", 32'd4, 1'b0);
    @(negedge clk);
    xact(2'b00, 12'hC82, 32'h0);
    check_resp("instreth_after_rst", 32'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
